// File: rtl/mips_rf_pkg.sv
// Shared types and helpers for the MIPS multi-port register file.
package mips_rf_pkg;

  typedef enum logic [1:0] {
    RF_ASYNC   = 2'd0,
    RF_WRFIRST = 2'd1,
    RF_RDFIRST = 2'd2
  } rf_mode_e;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // True when a read of this address must return zero because the entry is hardwired.
  function automatic logic rf_zero_read(input logic zero_reg_en, input logic [31:0] addr);
    return zero_reg_en && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Collapses all write ports aimed at one address into a single enable and data word.
// Later ports override earlier ones, so the highest-numbered matching port wins.
module rf_write_merge #(
  parameter int AWL = 5,
  parameter int DWL = 32,
  parameter int NWP = 2
) (
  input  logic [NWP-1:0]     wen,
  input  logic [NWP*AWL-1:0] wa,
  input  logic [NWP*DWL-1:0] wd,
  input  logic [AWL-1:0]     addr,
  output logic               hit,
  output logic [DWL-1:0]     data
);

  // Scan ports in ascending order so the last match (highest port) sticks.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWP; p++) begin
      if (wen[p] && (wa[p*AWL +: AWL] == addr)) begin
        hit  = 1'b1;
        data = wd[p*DWL +: DWL];
      end
    end
  end

endmodule

// File: rtl/mips_multiport_regfile.sv
// Parametrised multi-port register file with a deterministic clear sequence,
// highest-port-wins write merging, optional hardwired zero entry and three read modes.
module mips_multiport_regfile
  import mips_rf_pkg::*;
#(
  parameter int AWL      = 5,
  parameter int DWL      = 32,
  parameter int NRP      = 2,
  parameter int NWP      = 2,
  parameter int MODE     = 0,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NWP-1:0]     wen,
  input  logic [NWP*AWL-1:0] WA,
  input  logic [NWP*DWL-1:0] WD,
  input  logic [NRP*AWL-1:0] RA,
  output logic [NRP*DWL-1:0] RD,
  output logic               busy
);

  localparam int             DEPTH    = 2**AWL;
  localparam logic [AWL-1:0] LAST_IDX = AWL'(DEPTH - 1);
  localparam logic           ZR_EN    = (ZERO_REG != 0);

  rf_state_e      state_q;
  rf_state_e      state_d;
  logic [AWL-1:0] clr_idx_q;

  logic [DWL-1:0] mem    [DEPTH];
  logic           ent_hit[DEPTH];
  logic           ent_we [DEPTH];
  logic [DWL-1:0] ent_wd [DEPTH];
  logic [DWL-1:0] rd_val [NRP];

  // State register: reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RF_CLEAR;
    else     state_q <= state_d;
  end

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    state_d = state_q;
    if ((state_q == RF_CLEAR) && (clr_idx_q == LAST_IDX)) state_d = RF_READY;
  end

  // Output decode: busy for the whole clear sequence.
  always_comb begin
    busy = (state_q == RF_CLEAR);
  end

  // Clear index walks every entry once per clear sequence.
  always_ff @(posedge clk) begin
    if (rst)                        clr_idx_q <= '0;
    else if (state_q == RF_CLEAR)   clr_idx_q <= clr_idx_q + 1'b1;
  end

  // One merge per entry turns the port list into per-entry enable/data.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    localparam logic DROP = ZR_EN && (e == 0);
    rf_write_merge #(.AWL(AWL), .DWL(DWL), .NWP(NWP)) u_merge (
      .wen  (wen),
      .wa   (WA),
      .wd   (WD),
      .addr (AWL'(e)),
      .hit  (ent_hit[e]),
      .data (ent_wd[e])
    );
    assign ent_we[e] = ent_hit[e] && !DROP && (state_q == RF_READY) && !rst;
  end

  // Array update: zero one entry per cycle while clearing, else commit merged writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem[clr_idx_q] <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (ent_we[e]) mem[e] <= ent_wd[e];
        end
      end
    end
  end

  if (MODE == int'(RF_ASYNC)) begin : g_async
    // Combinational read of the current array contents.
    always_comb begin
      for (int r = 0; r < NRP; r++) begin
        rd_val[r] = '0;
        if (!busy && !rf_zero_read(ZR_EN, 32'(RA[r*AWL +: AWL])))
          rd_val[r] = mem[RA[r*AWL +: AWL]];
      end
    end
  end else begin : g_sync
    logic           byp_hit [NRP];
    logic [DWL-1:0] byp_data[NRP];

    if (MODE == int'(RF_WRFIRST)) begin : g_byp
      // Write-first: the same merge rule decides which write a read port sees.
      for (genvar r = 0; r < NRP; r++) begin : g_port
        rf_write_merge #(.AWL(AWL), .DWL(DWL), .NWP(NWP)) u_byp (
          .wen  (wen),
          .wa   (WA),
          .wd   (WD),
          .addr (RA[r*AWL +: AWL]),
          .hit  (byp_hit[r]),
          .data (byp_data[r])
        );
      end
    end else begin : g_nobyp
      // Read-first never forwards same-edge writes.
      always_comb begin
        for (int r = 0; r < NRP; r++) begin
          byp_hit[r]  = 1'b0;
          byp_data[r] = '0;
        end
      end
    end

    // Registered read: zero while resetting or clearing, else array or forwarded data.
    always_ff @(posedge clk) begin
      for (int r = 0; r < NRP; r++) begin
        if (rst || busy)
          rd_val[r] <= '0;
        else if (rf_zero_read(ZR_EN, 32'(RA[r*AWL +: AWL])))
          rd_val[r] <= '0;
        else if (byp_hit[r])
          rd_val[r] <= byp_data[r];
        else
          rd_val[r] <= mem[RA[r*AWL +: AWL]];
      end
    end
  end

  // Pack per-port read data onto the flat output bus.
  always_comb begin
    RD = '0;
    for (int r = 0; r < NRP; r++) RD[r*DWL +: DWL] = rd_val[r];
  end

endmodule

// File: tb/tb_mips_multiport_regfile.sv
// Self-checking bench: three register files (async/zero-reg, write-first/zero-reg,
// read-first/no-zero-reg) share one stimulus stream and are compared with an array model.
module tb_mips_multiport_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   wen = '0;
  logic [9:0]   WA  = '0;
  logic [63:0]  WD  = '0;
  logic [19:0]  RA  = '0;
  logic [127:0] rd_a, rd_w, rd_r;
  logic         busy_a, busy_w, busy_r;

  logic [31:0]  model_mem [32];
  int           n_compared   = 0;
  int           n_mismatched = 0;

  always #5 clk = ~clk;

  mips_multiport_regfile #(.AWL(5), .DWL(32), .NRP(4), .NWP(2), .MODE(0), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .WA(WA), .WD(WD), .RA(RA), .RD(rd_a), .busy(busy_a)
  );
  mips_multiport_regfile #(.AWL(5), .DWL(32), .NRP(4), .NWP(2), .MODE(1), .ZERO_REG(1)) dut_w (
    .clk(clk), .rst(rst), .wen(wen), .WA(WA), .WD(WD), .RA(RA), .RD(rd_w), .busy(busy_w)
  );
  mips_multiport_regfile #(.AWL(5), .DWL(32), .NRP(4), .NWP(2), .MODE(2), .ZERO_REG(0)) dut_r (
    .clk(clk), .rst(rst), .wen(wen), .WA(WA), .WD(WD), .RA(RA), .RD(rd_r), .busy(busy_r)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a, input bit zero_reg);
    if (zero_reg && a == 5'd0) return 32'h0;
    return model_mem[a];
  endfunction

  // One READY cycle: async check before the edge, registered checks after it.
  task automatic applyStimulus(input logic [1:0] w_en, input logic [9:0] w_addr,
                               input logic [63:0] w_data, input logic [19:0] r_addr);
    logic [127:0] pre_z1, pre_z0, post_z1;
    wen = w_en; WA = w_addr; WD = w_data; RA = r_addr;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      pre_z1[r*32 +: 32] = modelRead(r_addr[r*5 +: 5], 1'b1);
      pre_z0[r*32 +: 32] = modelRead(r_addr[r*5 +: 5], 1'b0);
    end
    checkOutput("async_rd", rd_a, pre_z1);
    for (int p = 0; p < 2; p++)
      if (w_en[p]) model_mem[w_addr[p*5 +: 5]] = w_data[p*32 +: 32];
    for (int r = 0; r < 4; r++) post_z1[r*32 +: 32] = modelRead(r_addr[r*5 +: 5], 1'b1);
    @(posedge clk); #1;
    checkOutput("wrfirst_rd", rd_w, post_z1);
    checkOutput("rdfirst_rd", rd_r, pre_z0);
    checkOutput("busy_ready", {125'd0, busy_a, busy_w, busy_r}, 128'd0);
    wen = '0;
  endtask

  // Reset, optionally restart the clear after some cycles, then time the clear.
  task automatic runClear(input int restart_after);
    int n;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy_on_rst", {125'd0, busy_a, busy_w, busy_r}, {125'd0, 3'b111});
    checkOutput("rst_rd_sync", rd_w | rd_r, 128'd0);
    rst = 1'b0;
    if (restart_after > 0) begin
      repeat (restart_after) @(posedge clk);
      #1;
      checkOutput("busy_mid_clear", {127'd0, busy_a}, 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    n = 0;
    while (busy_a && n < 40) begin
      wen = 2'b11; WA = 10'($urandom); WD = {$urandom, $urandom}; RA = 20'($urandom);
      @(negedge clk);
      checkOutput("clear_rd_async", rd_a, 128'd0);
      @(posedge clk); #1;
      n++;
      checkOutput("clear_rd_wr", rd_w, 128'd0);
      checkOutput("clear_rd_rd", rd_r, 128'd0);
    end
    wen = '0;
    checkOutput("clear_len", 128'(n), 128'd32);
    checkOutput("busy_after_clear", {125'd0, busy_a, busy_w, busy_r}, 128'd0);
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
  endtask

  task automatic readAll();
    for (int a = 0; a < 32; a += 4)
      applyStimulus(2'b00, 10'd0, 64'd0, {5'(a + 3), 5'(a + 2), 5'(a + 1), 5'(a)});
  endtask

  task automatic randomCycles(input int count);
    logic [9:0] wa;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 1) == 0) wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      else                           wa = 10'($urandom);
      applyStimulus(2'($urandom), wa, {$urandom, $urandom}, 20'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    @(posedge clk); #1;

    runClear(0);
    readAll();

    // Same-address conflict: port 1 must win.
    applyStimulus(2'b11, {5'd7, 5'd7}, {32'h5555_5555, 32'hAAAA_AAAA}, {4{5'd7}});
    checkOutput("conflict_async", {96'd0, rd_a[31:0]}, {96'd0, 32'h5555_5555});
    checkOutput("conflict_wrfirst", {96'd0, rd_w[31:0]}, {96'd0, 32'h5555_5555});

    // Zero register versus ordinary entry 0.
    applyStimulus(2'b01, {5'd0, 5'd0}, {32'h0, 32'hDEAD_BEEF}, 20'd0);
    applyStimulus(2'b00, 10'd0, 64'd0, 20'd0);
    checkOutput("zero_async", rd_a, 128'd0);
    checkOutput("zero_wrfirst", rd_w, 128'd0);
    checkOutput("nozero_rdfirst", rd_r, {4{32'hDEAD_BEEF}});

    // Write-first versus read-first on a same-edge write.
    applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h11}, 20'd0);
    applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h22}, {15'd0, 5'd3});
    checkOutput("wrfirst_same_edge", {96'd0, rd_w[31:0]}, {96'd0, 32'h22});
    checkOutput("rdfirst_same_edge", {96'd0, rd_r[31:0]}, {96'd0, 32'h11});
    applyStimulus(2'b00, 10'd0, 64'd0, {15'd0, 5'd3});
    checkOutput("rdfirst_next", {96'd0, rd_r[31:0]}, {96'd0, 32'h22});

    // Four read ports, duplicated address.
    applyStimulus(2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 20'd0);
    applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h3}, 20'd0);
    applyStimulus(2'b00, 10'd0, 64'd0, {5'd1, 5'd3, 5'd2, 5'd1});
    checkOutput("ports_async", rd_a, {32'h1, 32'h3, 32'h2, 32'h1});
    checkOutput("ports_rdfirst", rd_r, {32'h1, 32'h3, 32'h2, 32'h1});

    randomCycles(300);

    // Restart the clear partway through; contents must be zero afterwards.
    runClear(10);
    readAll();
    randomCycles(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
